// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-side register block: register indices,
// VRAM handshake state encoding and VRAM address increments.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL0    = 3'd0;
  localparam logic [2:0] REG_CTRL1    = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_OAM_ADDR = 3'd3;
  localparam logic [2:0] REG_OAM_DATA = 3'd4;
  localparam logic [2:0] REG_SCROLL   = 3'd5;
  localparam logic [2:0] REG_ADDR     = 3'd6;
  localparam logic [2:0] REG_DATA     = 3'd7;

  localparam int VRAM_INC_1  = 1;
  localparam int VRAM_INC_32 = 32;

  typedef enum logic [1:0] {
    VS_IDLE   = 2'd0,
    VS_WR_REQ = 2'd1,
    VS_RD_REQ = 2'd2
  } vram_state_e;

endpackage

// File: rtl/ppu_vram_port.sv
// VRAM request/acknowledge handshake: one outstanding read or write at a time,
// request held stable until the memory side acknowledges.
module ppu_vram_port
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_start_i,
  input  logic       rd_start_i,
  input  logic [7:0] wdata_i,
  input  logic       ack_i,
  output logic       req_o,
  output logic       we_o,
  output logic [7:0] wdata_o,
  output logic       idle_o,
  output logic       done_o,
  output logic       rd_done_o
);

  vram_state_e state_q, state_d;
  logic [7:0]  wdata_q, wdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= VS_IDLE;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
    end
  end

  // An ack seen in IDLE is stale (e.g. from a request abandoned by reset).
  always_comb begin
    state_d   = state_q;
    wdata_d   = wdata_q;
    done_o    = 1'b0;
    rd_done_o = 1'b0;
    case (state_q)
      VS_IDLE: begin
        if (wr_start_i) begin
          state_d = VS_WR_REQ;
          wdata_d = wdata_i;
        end else if (rd_start_i) begin
          state_d = VS_RD_REQ;
        end
      end
      VS_WR_REQ: begin
        if (ack_i) begin
          state_d = VS_IDLE;
          done_o  = 1'b1;
        end
      end
      VS_RD_REQ: begin
        if (ack_i) begin
          state_d   = VS_IDLE;
          done_o    = 1'b1;
          rd_done_o = 1'b1;
        end
      end
      default: state_d = VS_IDLE;
    endcase
  end

  assign req_o   = (state_q != VS_IDLE);
  assign we_o    = (state_q == VS_WR_REQ);
  assign idle_o  = (state_q == VS_IDLE);
  assign wdata_o = wdata_q;

endmodule

// File: rtl/ppu_cpu_reg_ctrl.sv
// CPU-facing PPU register window: address decode, control/scroll/OAM registers,
// the shared write toggle, VRAM address/read buffer and NMI generation.
module ppu_cpu_reg_ctrl
  import ppu_pkg::*;
#(
  parameter logic [15:0] REG_BASE = 16'h2000,
  parameter int          VRAM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  input  logic               cpu_read,
  input  logic               cpu_write,
  output logic [7:0]         cpu_rdata,
  input  logic [7:0]         ppu_status_in,
  output logic [7:0]         ppu_ctrl0,
  output logic [7:0]         ppu_ctrl1,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic [7:0]         oam_addr,
  output logic               oam_we,
  output logic [7:0]         oam_wdata,
  input  logic [7:0]         oam_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_req,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic               vram_ack,
  output logic               nmi_n
);

  logic [7:0]         ctrl0_q, ctrl0_d, ctrl1_q, ctrl1_d;
  logic [7:0]         scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
  logic [7:0]         oam_addr_q, oam_addr_d, oam_wdata_q, oam_wdata_d;
  logic               oam_we_q, oam_we_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d, vram_inc;
  logic [7:0]         rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic               w_q, w_d, nmi_n_q, nmi_n_d;

  logic       hit, wr_acc, rd_acc, rd_miss;
  logic [2:0] idx;
  logic       vp_idle, vp_done, vp_rd_done;
  logic       unused_bits;

  assign unused_bits = ^{cpu_addr[12:3], ppu_status_in[4:0]};

  // A write strobe always wins over a simultaneous read strobe.
  assign hit     = (cpu_addr[15:13] == REG_BASE[15:13]);
  assign idx     = cpu_addr[2:0];
  assign wr_acc  = cpu_write & hit;
  assign rd_acc  = cpu_read & ~cpu_write & hit;
  assign rd_miss = cpu_read & ~cpu_write & ~hit;

  assign vram_inc = ctrl0_q[2] ? VRAM_AW'(VRAM_INC_32) : VRAM_AW'(VRAM_INC_1);

  ppu_vram_port u_vram_port (
    .clk        (clk),
    .rst        (rst),
    .wr_start_i (wr_acc & (idx == REG_DATA)),
    .rd_start_i (rd_acc & (idx == REG_DATA)),
    .wdata_i    (cpu_wdata),
    .ack_i      (vram_ack),
    .req_o      (vram_req),
    .we_o       (vram_we),
    .wdata_o    (vram_wdata),
    .idle_o     (vp_idle),
    .done_o     (vp_done),
    .rd_done_o  (vp_rd_done)
  );

  always_comb begin
    ctrl0_d     = ctrl0_q;
    ctrl1_d     = ctrl1_q;
    scroll_x_d  = scroll_x_q;
    scroll_y_d  = scroll_y_q;
    oam_addr_d  = oam_addr_q;
    oam_we_d    = 1'b0;
    oam_wdata_d = oam_wdata_q;
    vram_addr_d = vram_addr_q;
    rbuf_d      = rbuf_q;
    rdata_d     = rdata_q;
    w_d         = w_q;
    nmi_n_d     = ~(ppu_status_in[7] & ctrl0_q[7]);

    // OAM address advances once the write pulse has been presented.
    if (oam_we_q)   oam_addr_d  = oam_addr_q + 8'd1;
    if (vp_done)    vram_addr_d = vram_addr_q + vram_inc;
    if (vp_rd_done) rbuf_d      = vram_rdata;

    if (wr_acc) begin
      case (idx)
        REG_CTRL0:    ctrl0_d    = cpu_wdata;
        REG_CTRL1:    ctrl1_d    = cpu_wdata;
        REG_OAM_ADDR: oam_addr_d = cpu_wdata;
        REG_OAM_DATA: begin
          oam_we_d    = 1'b1;
          oam_wdata_d = cpu_wdata;
        end
        REG_SCROLL: begin
          if (w_q) scroll_y_d = cpu_wdata;
          else     scroll_x_d = cpu_wdata;
          w_d = ~w_q;
        end
        REG_ADDR: begin
          // Restart from the held address so a coincident ack increment is discarded.
          vram_addr_d = vram_addr_q;
          if (w_q) vram_addr_d[7:0]         = cpu_wdata;
          else     vram_addr_d[VRAM_AW-1:8] = cpu_wdata[VRAM_AW-9:0];
          w_d = ~w_q;
        end
        default: ;
      endcase
    end else if (rd_acc) begin
      case (idx)
        REG_STATUS: begin
          rdata_d = {ppu_status_in[7:5], 5'b0};
          w_d     = 1'b0;
        end
        REG_OAM_DATA: rdata_d = oam_rdata;
        REG_DATA:     rdata_d = rbuf_q;
        default:      rdata_d = 8'h00;
      endcase
    end else if (rd_miss) begin
      rdata_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl0_q     <= 8'h00;
      ctrl1_q     <= 8'h00;
      scroll_x_q  <= 8'h00;
      scroll_y_q  <= 8'h00;
      oam_addr_q  <= 8'h00;
      oam_we_q    <= 1'b0;
      oam_wdata_q <= 8'h00;
      vram_addr_q <= '0;
      rbuf_q      <= 8'h00;
      rdata_q     <= 8'h00;
      w_q         <= 1'b0;
      nmi_n_q     <= 1'b1;
    end else begin
      ctrl0_q     <= ctrl0_d;
      ctrl1_q     <= ctrl1_d;
      scroll_x_q  <= scroll_x_d;
      scroll_y_q  <= scroll_y_d;
      oam_addr_q  <= oam_addr_d;
      oam_we_q    <= oam_we_d;
      oam_wdata_q <= oam_wdata_d;
      vram_addr_q <= vram_addr_d;
      rbuf_q      <= rbuf_d;
      rdata_q     <= rdata_d;
      w_q         <= w_d;
      nmi_n_q     <= nmi_n_d;
    end
  end

  assign ppu_ctrl0 = ctrl0_q;
  assign ppu_ctrl1 = ctrl1_q;
  assign scroll_x  = scroll_x_q;
  assign scroll_y  = scroll_y_q;
  assign oam_addr  = oam_addr_q;
  assign oam_we    = oam_we_q;
  assign oam_wdata = oam_wdata_q;
  assign vram_addr = vram_addr_q;
  assign cpu_rdata = rdata_q;
  assign nmi_n     = nmi_n_q;

endmodule

// File: tb/tb_ppu_cpu_reg_ctrl.sv
// Bench for ppu_cpu_reg_ctrl: directed scenarios plus a randomized register
// traffic run checked against a register-level behavioural model.
module tb_ppu_cpu_reg_ctrl;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_read, cpu_write;
  logic [7:0]    ppu_status_in;
  logic [7:0]    ppu_ctrl0, ppu_ctrl1, scroll_x, scroll_y;
  logic [7:0]    oam_addr, oam_wdata, oam_rdata;
  logic          oam_we;
  logic [AW-1:0] vram_addr;
  logic          vram_req, vram_we, vram_ack;
  logic [7:0]    vram_wdata, vram_rdata;
  logic          nmi_n;

  int vectors = 0;
  int errors  = 0;

  // Model of the architecturally visible state
  logic [7:0]    m_ctrl0, m_ctrl1, m_sx, m_sy, m_oam, m_buf, m_pd;
  logic [AW-1:0] m_va;
  logic          m_w, m_busy, m_pwe;

  ppu_cpu_reg_ctrl #(.REG_BASE(16'h2000), .VRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
    .ppu_status_in(ppu_status_in), .ppu_ctrl0(ppu_ctrl0), .ppu_ctrl1(ppu_ctrl1),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .oam_addr(oam_addr), .oam_we(oam_we),
    .oam_wdata(oam_wdata), .oam_rdata(oam_rdata), .vram_addr(vram_addr),
    .vram_req(vram_req), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .vram_ack(vram_ack), .nmi_n(nmi_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_ctrl0 = 0; m_ctrl1 = 0; m_sx = 0; m_sy = 0; m_oam = 0; m_buf = 0; m_pd = 0;
    m_va = 0; m_w = 0; m_busy = 0; m_pwe = 0;
  endtask

  task automatic model_wr(input logic [15:0] a, input logic [7:0] d);
    if (a[15:13] != 3'b001) return;
    case (a[2:0])
      3'd0: m_ctrl0 = d;
      3'd1: m_ctrl1 = d;
      3'd3: m_oam = d;
      3'd4: m_oam = m_oam + 8'd1;
      3'd5: begin if (m_w) m_sy = d; else m_sx = d; m_w = ~m_w; end
      3'd6: begin if (m_w) m_va[7:0] = d; else m_va[13:8] = d[5:0]; m_w = ~m_w; end
      3'd7: if (!m_busy) begin m_busy = 1; m_pwe = 1; m_pd = d; end
      default: ;
    endcase
  endtask

  task automatic model_rd(input logic [15:0] a, output logic [7:0] r);
    r = 8'h00;
    if (a[15:13] != 3'b001) return;
    case (a[2:0])
      3'd2: begin r = ppu_status_in & 8'hE0; m_w = 0; end
      3'd4: r = oam_rdata;
      3'd7: begin r = m_buf; if (!m_busy) begin m_busy = 1; m_pwe = 0; end end
      default: r = 8'h00;
    endcase
  endtask

  task automatic model_ack(input logic [7:0] d);
    if (!m_busy) return;
    if (!m_pwe) m_buf = d;
    m_va = m_va + (m_ctrl0[2] ? AW'(32) : AW'(1));
    m_busy = 0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
    model_wr(a, d);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] got, output logic [7:0] exp);
    cpu_addr = a; cpu_read = 1'b1;
    model_rd(a, exp);
    tick();
    cpu_read = 1'b0;
    got = cpu_rdata;
  endtask

  task automatic ack_after(input int n, input logic [7:0] d);
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (vram_req !== 1'b1) begin
        errors++; $display("FAIL req_hold: vram_req=%b required 1", vram_req);
      end
      tick();
    end
    vram_rdata = d; vram_ack = 1'b1;
    tick();
    vram_ack = 1'b0;
    model_ack(d);
  endtask

  task automatic test_reset();
    rst = 1'b0; model_reset();
    tick(); tick();
    vectors++;
    if ({ppu_ctrl0, ppu_ctrl1, scroll_x, scroll_y, oam_addr, cpu_rdata, vram_addr,
         vram_req, oam_we, nmi_n} !== {48'h0, 14'h0, 3'b001}) begin
      errors++;
      $display("FAIL reset_state: got c0=%h c1=%h sx=%h sy=%h oa=%h rd=%h va=%h req=%b we=%b nmi=%b required zeros, nmi_n=1",
               ppu_ctrl0, ppu_ctrl1, scroll_x, scroll_y, oam_addr, cpu_rdata, vram_addr, vram_req, oam_we, nmi_n);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_vram_write();
    bus_wr(16'h2006, 8'h21);
    bus_wr(16'h2006, 8'h08);
    vectors++;
    if (vram_addr !== 14'h2108) begin errors++; $display("FAIL addr_load: %h required 2108", vram_addr); end
    bus_wr(16'h2007, 8'h55);
    vectors++;
    if ({vram_req, vram_we, vram_wdata, vram_addr} !== {2'b11, 8'h55, 14'h2108}) begin
      errors++;
      $display("FAIL vram_wr_req: req=%b we=%b wd=%h va=%h required 1 1 55 2108", vram_req, vram_we, vram_wdata, vram_addr);
    end
    ack_after(3, 8'h00);
    vectors++;
    if ({vram_req, vram_addr} !== {1'b0, 14'h2109}) begin
      errors++; $display("FAIL vram_wr_done: req=%b va=%h required 0 2109", vram_req, vram_addr);
    end
  endtask

  task automatic test_vram_read_wrap();
    logic [7:0] got, exp;
    bus_rd(16'h2002, got, exp);
    bus_wr(16'h2000, 8'h04);
    bus_wr(16'h2006, 8'h3F);
    bus_wr(16'h2006, 8'hF0);
    bus_rd(16'h2007, got, exp);
    vectors++;
    if (got !== exp) begin errors++; $display("FAIL rd_old_buf: %h required %h", got, exp); end
    vectors++;
    if ({vram_req, vram_we, vram_addr} !== {2'b10, 14'h3FF0}) begin
      errors++; $display("FAIL vram_rd_req: req=%b we=%b va=%h required 1 0 3ff0", vram_req, vram_we, vram_addr);
    end
    ack_after(1, 8'hAB);
    vectors++;
    if (vram_addr !== 14'h0010) begin errors++; $display("FAIL addr_wrap: %h required 0010", vram_addr); end
    bus_rd(16'h2007, got, exp);
    vectors++;
    if (got !== 8'hAB) begin errors++; $display("FAIL rd_new_buf: %h required ab", got); end
    ack_after(0, 8'h3C);
    bus_wr(16'h2000, 8'h00);
  endtask

  task automatic test_scroll();
    logic [7:0] got, exp, sy0;
    bus_rd(16'h2002, got, exp);
    sy0 = scroll_y;
    bus_wr(16'h2005, 8'h12);
    bus_rd(16'h2002, got, exp);
    bus_wr(16'h2005, 8'h34);
    vectors++;
    if ({scroll_x, scroll_y} !== {8'h34, sy0}) begin
      errors++; $display("FAIL scroll_toggle_clear: sx=%h sy=%h required 34 %h", scroll_x, scroll_y, sy0);
    end
  endtask

  task automatic test_nmi();
    logic [7:0] got, exp;
    ppu_status_in = 8'hC0;
    tick();
    bus_wr(16'h2000, 8'h80);
    vectors++;
    if (nmi_n !== 1'b1) begin errors++; $display("FAIL nmi_latency: nmi_n=%b required 1", nmi_n); end
    tick();
    vectors++;
    if (nmi_n !== 1'b0) begin errors++; $display("FAIL nmi_assert: nmi_n=%b required 0", nmi_n); end
    bus_rd(16'h2002, got, exp);
    vectors++;
    if (got !== 8'hC0) begin errors++; $display("FAIL status_read: %h required c0", got); end
    ppu_status_in = 8'h00;
    bus_wr(16'h2000, 8'h00);
    tick();
  endtask

  task automatic test_oam();
    bus_wr(16'h3FFB, 8'h07);
    vectors++;
    if (oam_addr !== 8'h07) begin errors++; $display("FAIL oam_addr_mirror: %h required 07", oam_addr); end
    bus_wr(16'h2003, 8'hFF);
    bus_wr(16'h2004, 8'h5A);
    vectors++;
    if ({oam_we, oam_wdata, oam_addr} !== {1'b1, 8'h5A, 8'hFF}) begin
      errors++; $display("FAIL oam_we_pulse: we=%b wd=%h oa=%h required 1 5a ff", oam_we, oam_wdata, oam_addr);
    end
    tick();
    vectors++;
    if ({oam_we, oam_addr} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL oam_addr_wrap: we=%b oa=%h required 0 00", oam_we, oam_addr);
    end
  endtask

  task automatic test_drop_and_reset();
    logic [7:0] got, exp, buf0;
    logic [AW-1:0] va0;
    va0 = vram_addr; buf0 = m_buf;
    bus_wr(16'h2007, 8'h11);
    bus_wr(16'h2007, 8'h22);
    vectors++;
    if ({vram_req, vram_we, vram_wdata} !== {2'b11, 8'h11}) begin
      errors++; $display("FAIL drop_wr: req=%b we=%b wd=%h required 1 1 11", vram_req, vram_we, vram_wdata);
    end
    bus_rd(16'h2007, got, exp);
    ack_after(1, 8'hEE);
    vectors++;
    if ({got, m_buf, vram_addr} !== {buf0, buf0, va0 + AW'(1)}) begin
      errors++; $display("FAIL drop_rd: rd=%h va=%h required %h %h", got, vram_addr, buf0, va0 + AW'(1));
    end
    // Address write coincident with ack overrides the increment
    bus_rd(16'h2002, got, exp);
    bus_wr(16'h2006, 8'h05);
    bus_wr(16'h2007, 8'h66);
    cpu_addr = 16'h2006; cpu_wdata = 8'h77; cpu_write = 1'b1; vram_ack = 1'b1;
    tick();
    cpu_write = 1'b0; vram_ack = 1'b0;
    m_busy = 0; m_va = 14'h0577; m_w = 0;
    vectors++;
    if ({vram_req, vram_addr} !== {1'b0, 14'h0577}) begin
      errors++; $display("FAIL addr_wins_ack: req=%b va=%h required 0 0577", vram_req, vram_addr);
    end
    // Reset in the middle of a request, then a stale ack
    bus_wr(16'h2007, 8'h99);
    rst = 1'b0; model_reset();
    #2;
    vectors++;
    if ({vram_req, vram_addr, ppu_ctrl0, scroll_x, oam_addr, cpu_rdata, nmi_n} !== {1'b0, 14'h0, 32'h0, 1'b1}) begin
      errors++; $display("FAIL reset_mid_req: req=%b va=%h nmi=%b required 0 0000 1", vram_req, vram_addr, nmi_n);
    end
    tick();
    rst = 1'b1;
    vram_ack = 1'b1; tick(); vram_ack = 1'b0;
    tick();
    vectors++;
    if ({vram_req, vram_addr} !== {1'b0, 14'h0}) begin
      errors++; $display("FAIL late_ack: req=%b va=%h required 0 0000", vram_req, vram_addr);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d, got, exp;
    logic [2:0]  top;
    logic [55:0] act, mdl;
    for (int i = 0; i < 300; i++) begin
      ppu_status_in = 8'($urandom);
      oam_rdata     = 8'($urandom);
      top = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 8)) : 3'b001;
      a   = {top, 13'($urandom)};
      d   = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        bus_wr(a, d);
        if (top == 3'b001 && a[2:0] == 3'd4) begin
          vectors++;
          if ({oam_we, oam_wdata} !== {1'b1, d}) begin
            errors++; $display("FAIL rnd_oam_we: we=%b wd=%h required 1 %h", oam_we, oam_wdata, d);
          end
        end
      end else begin
        bus_rd(a, got, exp);
        vectors++;
        if (got !== exp) begin errors++; $display("FAIL rnd_read a=%h: %h required %h", a, got, exp); end
      end
      if (m_busy) begin
        vectors++;
        if ({vram_req, vram_we, vram_addr} !== {1'b1, m_pwe, m_va} || (m_pwe && vram_wdata !== m_pd)) begin
          errors++; $display("FAIL rnd_vram_req: req=%b we=%b va=%h wd=%h required 1 %b %h %h",
                             vram_req, vram_we, vram_addr, vram_wdata, m_pwe, m_va, m_pd);
        end
        ack_after($urandom_range(0, 3), 8'($urandom));
      end
      tick();
      act = {ppu_ctrl0, ppu_ctrl1, scroll_x, scroll_y, oam_addr, vram_addr, nmi_n, vram_req};
      mdl = {m_ctrl0, m_ctrl1, m_sx, m_sy, m_oam, m_va, ~(ppu_status_in[7] & m_ctrl0[7]), 1'b0};
      vectors++;
      if (act !== mdl) begin errors++; $display("FAIL rnd_state #%0d: %h required %h", i, act, mdl); end
    end
  endtask

  initial begin
    cpu_addr = 0; cpu_wdata = 0; cpu_read = 0; cpu_write = 0;
    ppu_status_in = 0; oam_rdata = 0; vram_rdata = 0; vram_ack = 0; rst = 0;
    model_reset();
    test_reset();
    test_vram_write();
    test_vram_read_wrap();
    test_scroll();
    test_nmi();
    test_oam();
    test_drop_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
